// File: rtl/md_sched_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencer.
package md_sched_pkg;

  localparam logic [1:0] XOP_MULTU = 2'd0;
  localparam logic [1:0] XOP_MULT  = 2'd1;
  localparam logic [1:0] XOP_DIVU  = 2'd2;
  localparam logic [1:0] XOP_DIV   = 2'd3;

  // For mthi/mtlo/mfhi/mflo, this xop bit selects HI (1) or LO (0).
  localparam int unsigned XOP_HI_BIT = 0;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit mult/div datapath: o_res = {HI, LO}; o_div0 flags divide by zero.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_xop,
  output logic [63:0] o_res,
  output logic        o_div0
);

  logic [63:0] w_pa;
  logic [63:0] w_pb;
  logic        w_sdiv;
  logic [31:0] w_na;
  logic [31:0] w_nb;
  logic [31:0] w_bd;
  logic [31:0] w_q;
  logic [31:0] w_r;

  always_comb begin
    w_pa   = {32'b0, i_a};
    w_pb   = {32'b0, i_b};
    w_sdiv = (i_xop == XOP_DIV);
    w_na   = i_a;
    w_nb   = i_b;
    w_q    = '0;
    w_r    = '0;
    o_res  = '0;
    o_div0 = i_xop[1] & (i_b == '0);

    if (i_xop == XOP_MULT) begin
      w_pa = {{32{i_a[31]}}, i_a};
      w_pb = {{32{i_b[31]}}, i_b};
    end

    // Signed divide runs on magnitudes so the 0x80000000 / -1 case wraps cleanly.
    if (w_sdiv && i_a[31]) w_na = -i_a;
    if (w_sdiv && i_b[31]) w_nb = -i_b;
    w_bd = (w_nb == '0) ? 32'd1 : w_nb;
    w_q  = w_na / w_bd;
    w_r  = w_na % w_bd;
    if (w_sdiv && (i_a[31] ^ i_b[31])) w_q = -w_q;
    if (w_sdiv && i_a[31])             w_r = -w_r;

    if (i_xop[1]) o_res = {w_r, w_q};
    else          o_res = w_pa * w_pb;
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: busy counter, pending result, HI/LO and D-stage stall.
// Optional MD_DIV0_FAST_EN: divide by zero completes immediately without entering BUSY.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xst,
  input  logic [1:0]  xop,
  input  logic        xwe,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        xu_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_pend;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_res;
  logic        w_div0;
  logic        w_go;

  md_arith u_arith (
    .i_a    (a),
    .i_b    (b),
    .i_xop  (xop),
    .o_res  (w_res),
    .o_div0 (w_div0)
  );

  assign w_go = xst & ~cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
`ifdef MD_DIV0_FAST_EN
            if (!w_div0) begin
              r_pend  <= w_res;
              r_cnt   <= xop[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
              r_busy  <= 1'b1;
              r_state <= ST_BUSY;
            end
`else
            // Divide by zero re-commits the current HI/LO, leaving them unchanged.
            r_pend  <= w_div0 ? {r_hi, r_lo} : w_res;
            r_cnt   <= xop[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
`endif
          end else if (xwe && !cancel) begin
            if (xop[XOP_HI_BIT]) r_hi <= a;
            else                 r_lo <= a;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_pend[63:32];
            r_lo    <= r_pend[31:0];
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = xu_d & (r_busy | w_go);
  assign rdata = xop[XOP_HI_BIT] ? r_hi : r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Directed scoreboard bench for md_sched; honours MD_DIV0_FAST_EN for the divide-by-zero step.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        xst, xwe, cancel, xu_d;
  logic [1:0]  xop;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] sb[$];

  md_sched #(.MULT_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk(clk), .reset(reset), .xst(xst), .xop(xop), .xwe(xwe), .a(a), .b(b),
    .cancel(cancel), .xu_d(xu_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && (xst || xwe))) else begin
        errors++;
        $error("FAIL illegal_start_while_busy xst=%0b xwe=%0b", xst, xwe);
      end
      assert (!(xst && xwe)) else begin
        errors++;
        $error("FAIL illegal_xst_xwe_together");
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, push expected {HI,LO}, count busy cycles and pop/compare at completion.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp, input int lat,
                        input logic xud);
    int n;
    logic [63:0] e;
    @(negedge clk);
    xop = op; a = av; b = bv; xst = 1'b1; xu_d = xud;
    sb.push_back(exp);
    #1 check({tag, "_stall_start"}, 64'(stall), 64'(xud));
    @(negedge clk);
    xst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (xud) check({tag, "_stall_busy"}, 64'(stall), 64'(1));
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    check({tag, "_stall_after"}, 64'(stall), 64'(0));
    e = sb.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    xu_d = 1'b0;
  endtask

  task automatic write_hilo(input logic sel, input logic [31:0] v);
    @(negedge clk);
    xop = {1'b0, sel}; a = v; xwe = 1'b1;
    @(negedge clk);
    xwe = 1'b0;
  endtask

  initial begin
    int div0_lat;
    logic [31:0] ra, rb;
    longint unsigned up;
    reset = 1'b1; xst = 1'b0; xwe = 1'b0; cancel = 1'b0; xu_d = 1'b1;
    xop = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    reset = 1'b0; xu_d = 1'b0;

    run_op("mult",  2'd1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5, 1'b1);
    run_op("multu", 2'd0, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 5, 1'b0);
    run_op("div",   2'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b0);
    run_op("divu",  2'd2, 32'd7, 32'd2, {32'd1, 32'd3}, 10, 1'b1);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      up = 64'(ra) * 64'(rb);
      run_op("multu_rand", 2'd0, ra, rb, up, 5, 1'b0);
    end

    write_hilo(1'b1, 32'h1234);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo_kept", 64'(lo), 64'(up[31:0]));
    xop = 2'd1; #1;
    check("mfhi_rdata", 64'(rdata), 64'h1234);

    write_hilo(1'b1, 32'h11);
    write_hilo(1'b0, 32'h22);
    check("mtlo_rdata", 64'(rdata), 64'h22);

    @(negedge clk);
    xop = 2'd1; a = 32'd3; b = 32'd4; xst = 1'b1; cancel = 1'b1; xu_d = 1'b1;
    #1 check("cancel_stall", 64'(stall), 64'(0));
    @(negedge clk);
    xst = 1'b0; cancel = 1'b0; xu_d = 1'b0;
    check("cancel_busy", 64'(busy), 64'(0));
    check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});

`ifdef MD_DIV0_FAST_EN
    div0_lat = 0;
`else
    div0_lat = 10;
`endif
    run_op("div0", 2'd3, 32'd99, 32'd0, {32'h11, 32'h22}, div0_lat, 1'b0);

    @(negedge clk);
    xop = 2'd1; a = 32'h55; b = 32'h66; xst = 1'b1;
    @(negedge clk);
    xst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hilo", {hi, lo}, 64'(0));
    repeat (8) @(negedge clk);
    check("rst_no_commit_busy", 64'(busy), 64'(0));
    check("rst_no_commit_hilo", {hi, lo}, 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the shared HI/LO multiply/divide resource of the 5-stage MIPS core.
- Takes the decoder's E-stage controls: start, 2-bit op, HI/LO write enable, plus an "uses HI/LO" flag for the instruction currently in D.
- Holds HI/LO, runs a multi-cycle busy counter and commits results when it expires.
- Drives the pipeline stall for any HI/LO instruction that reaches D while the unit is occupied.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (>=1).
- DIV_LAT, 10, busy cycles for div/divu (>=1).
- CW, 4, counter width; must satisfy 2^CW > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- xst  in  1  E-stage start of mult/multu/div/divu.
- xop  in  2  0=multu, 1=mult, 2=divu, 3=div; for mt/mf: 1=HI, 0=LO.
- xwe  in  1  E-stage mthi/mtlo write.
- a  in  32  rs operand (E stage).
- b  in  32  rt operand (E stage).
- cancel  in  1  exception/flush this cycle; squashes xst and xwe.
- xu_d  in  1  instruction in D uses HI/LO (mult/div/mf/mt).
- busy  out  1  unit occupied.
- stall  out  1  xu_d & (busy | (xst & ~cancel)).
- hi  out  32  HI register.
- lo  out  32  LO register.
- rdata  out  32  mf read data: xop[0] ? hi : lo (combinational).

Behaviour:
- Reset values: busy=0, hi=0, lo=0, counter=0, pending results=0, state=IDLE.
- Reset has priority over every other input, including mid-operation; a pending result is discarded.
- States: IDLE and BUSY.
- IDLE, xst & ~cancel at edge E:
  - latch the full 64-bit result into pending registers;
  - load counter with MULT_LAT (xop<2) or DIV_LAT;
  - go to BUSY.
- BUSY: counter decrements each edge. At the edge where counter==1, pending {HI,LO} is committed and the state returns to IDLE.
- Timing: with start latched at edge E, busy=1 for exactly LAT cycles after E, and new hi/lo are visible in the cycle after the last busy cycle.
- Multiply: multu uses the unsigned 64-bit product, mult the signed one; HI=[63:32], LO=[31:0].
- Divide:
  - LO=quotient, truncated toward zero; HI=remainder, with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: the full DIV_LAT busy period still runs; HI and LO are left unchanged at commit.
- xwe & ~cancel in IDLE: at the next edge, hi<=a if xop[0], else lo<=a.
- xst or xwe while BUSY: ignored. This is illegal given stall; the bench asserts it never occurs.
- xst and xwe together: xst wins and xwe is dropped. Also illegal and asserted.
- cancel: blocks state and register changes for that cycle's xst/xwe only. An operation already in BUSY is not aborted.
- rdata reads the current registers. It does not bypass the pending result; the stall rule makes a bypass unnecessary.
- stall is purely combinational and never registered.

Optional Feature:
- MD_DIV0_FAST_EN defined: div/divu with b==0 does not enter BUSY, and HI/LO are unchanged. busy stays 0, so stall only reflects xst for that cycle.
- Undefined: divide by zero takes the normal DIV_LAT busy period.

Decomposition:
- Shared package:
  - XOP_MULTU/XOP_MULT/XOP_DIVU/XOP_DIV encodings;
  - the HI/LO select bit convention;
  - default MULT_LAT/DIV_LAT.
- One sub-module, md_arith: combinational 64-bit mult/div result from a, b, xop, plus a div0 flag.
- md_sched keeps only the FSM, counter, pending/HI/LO registers and stall logic.

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=2:
  - busy high exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFE;
  - multu with the same operands gives hi=1, lo=0xFFFFFFFE.
- div a=-7 b=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=2 gives lo=3, hi=1.
- xwe xop=1 a=0x1234 in IDLE: hi=0x1234 next cycle, lo unchanged, rdata=0x1234 with xop=1.
- xst with xu_d=1 in the same cycle: stall=1 that cycle and for all 5 busy cycles, stall=0 afterwards. With xst & cancel, state stays IDLE, stall=0 and hi/lo are unchanged.
- div with b=0 after hi=0x11, lo=0x22: hi/lo stay 0x11/0x22. busy is 10 cycles without MD_DIV0_FAST_EN and 0 cycles with it.
- reset asserted at busy cycle 3 of a mult: next cycle busy=0, hi=lo=0, and no later commit occurs.
